// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: hold codes, address bus,
// controller state encoding and the per-stage hold bundle.
package pipe_hold_ctrl_pkg;

    localparam int INST_ADDR_W = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_bus;

    typedef enum logic [1:0] {
        HOLD_NONE  = 2'd0,
        HOLD_WAIT  = 2'd1,
        HOLD_FLUSH = 2'd2
    } holdpip_bus;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MDU_WAIT  = 2'd1,
        ST_IRQ_ENTER = 2'd2
    } ctrl_state_e;

    // Fields ordered front to back: PC, IF/ID, ID/EX, EX/MEM.
    typedef struct packed {
        holdpip_bus pc;
        holdpip_bus ifid;
        holdpip_bus idex;
        holdpip_bus exmem;
    } hold_set_t;

    localparam hold_set_t HS_RUN      = '{pc: HOLD_NONE, ifid: HOLD_NONE,  idex: HOLD_NONE,  exmem: HOLD_NONE};
    localparam hold_set_t HS_STALL    = '{pc: HOLD_WAIT, ifid: HOLD_WAIT,  idex: HOLD_WAIT,  exmem: HOLD_WAIT};
    localparam hold_set_t HS_MDU      = '{pc: HOLD_WAIT, ifid: HOLD_WAIT,  idex: HOLD_WAIT,  exmem: HOLD_FLUSH};
    localparam hold_set_t HS_DRAIN    = '{pc: HOLD_WAIT, ifid: HOLD_WAIT,  idex: HOLD_FLUSH, exmem: HOLD_NONE};
    localparam hold_set_t HS_REDIRECT = '{pc: HOLD_NONE, ifid: HOLD_FLUSH, idex: HOLD_FLUSH, exmem: HOLD_NONE};

endpackage

// File: rtl/pipe_hold_ctrl_timeout_cnt.sv
// Counts consecutive bus-wait cycles; one registered error pulse the cycle
// after the count reaches BUS_TIMEOUT, then the count restarts from zero.
module hold_timeout_cnt #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bus_wait,
    output logic bus_err
);

    localparam int TW = $clog2(BUS_TIMEOUT + 1);

    logic [TW-1:0] wait_cnt;
    logic          hit;

    assign hit = (wait_cnt == TW'(BUS_TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= hit;
            if (!bus_wait || hit) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + TW'(1);
            end
        end
    end

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Fixed-priority hazard controller: per-stage hold codes, PC redirects,
// interrupt entry sequencing and a saturating stall-cycle counter.
module pipe_hold_ctrl
    import pipe_hold_ctrl_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             jump_req_i,
    input  inst_addr_bus     jump_addr_i,
    input  logic             load_use_i,
    input  logic             mdu_start_i,
    input  logic             mdu_done_i,
    input  logic             bus_wait_i,
    input  logic             irq_req_i,
    input  inst_addr_bus     irq_addr_i,
    output holdpip_bus       hold_pc_o,
    output holdpip_bus       hold_ifid_o,
    output holdpip_bus       hold_idex_o,
    output holdpip_bus       hold_exmem_o,
    output logic             redirect_en_o,
    output inst_addr_bus     redirect_addr_o,
    output logic             irq_ack_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    ctrl_state_e  state;
    ctrl_state_e  state_nxt;
    logic         irq_pend;
    inst_addr_bus irq_addr_q;
    hold_set_t    hs;
    logic         any_wait;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch can infer a latch.
        state_nxt       = state;
        hs              = HS_RUN;
        redirect_en_o   = 1'b0;
        redirect_addr_o = '0;
        irq_ack_o       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus_wait_i) begin
                    hs = HS_STALL;
                end else if (jump_req_i) begin
                    hs              = HS_REDIRECT;
                    redirect_en_o   = 1'b1;
                    redirect_addr_o = jump_addr_i;
                end else if (mdu_start_i && !mdu_done_i) begin
                    hs        = HS_MDU;
                    state_nxt = ST_MDU_WAIT;
                end else if (irq_pend) begin
                    hs        = HS_DRAIN;
                    state_nxt = ST_IRQ_ENTER;
                end else if (load_use_i) begin
                    hs = HS_DRAIN;
                end
            end
            ST_MDU_WAIT: begin
                if (bus_wait_i) begin
                    hs = HS_STALL;
                end else if (!mdu_done_i) begin
                    hs = HS_MDU;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IRQ_ENTER: begin
                if (bus_wait_i) begin
                    hs = HS_STALL;
                end else begin
                    hs              = HS_REDIRECT;
                    redirect_en_o   = 1'b1;
                    redirect_addr_o = irq_addr_q;
                    // An entry interrupted by reset is abandoned, so it must not acknowledge.
                    irq_ack_o       = rst_n;
                    state_nxt       = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign hold_pc_o    = hs.pc;
    assign hold_ifid_o  = hs.ifid;
    assign hold_idex_o  = hs.idex;
    assign hold_exmem_o = hs.exmem;

    assign any_wait = (hs.pc == HOLD_WAIT) || (hs.ifid == HOLD_WAIT) ||
                      (hs.idex == HOLD_WAIT) || (hs.exmem == HOLD_WAIT);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state       <= ST_IDLE;
            irq_pend    <= 1'b0;
            irq_addr_q  <= '0;
            stall_cnt_o <= '0;
        end else begin
            state <= state_nxt;
            if (irq_ack_o) begin
                irq_pend <= 1'b0;
            end else if (irq_req_i && !irq_pend) begin
                irq_pend   <= 1'b1;
                irq_addr_q <= irq_addr_i;
            end
            if (any_wait && (stall_cnt_o != '1)) begin
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            end
        end
    end

    hold_timeout_cnt #(
        .BUS_TIMEOUT(BUS_TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus_wait(bus_wait_i),
        .bus_err (bus_err_o)
    );

endmodule

// File: doc/pipe_hold_ctrl.md
# pipe_hold_ctrl

Central hazard controller for the five-stage core. It collects stall and redirect requests from ID, EX, the multiply/divide unit, the bus interface and the interrupt controller, and arbitrates them by fixed priority. It drives the per-stage `hold_flag` buses consumed by the PC register and the if_id / id_ex / ex_mem pipeline registers, and issues PC redirects. It also sequences interrupt entry and counts stall cycles.

## Interface
Parameters:
- BUS_TIMEOUT, 255: consecutive `bus_wait_i` cycles before `bus_err_o` pulses.
- CNT_W, 32: width of the stall counter.

Ports (synchronous active-low reset):
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  synchronous reset, active low.
- jump_req_i  in  1  EX redirect (mispredict or unpredicted taken jump).
- jump_addr_i  in  `inst_addr_bus`  EX redirect target.
- load_use_i  in  1  ID load-use hazard.
- mdu_start_i  in  1  EX issues a multi-cycle MDU op this cycle.
- mdu_done_i  in  1  MDU result valid this cycle.
- bus_wait_i  in  1  fetch or data bus not ready.
- irq_req_i  in  1  interrupt request, level; sampled into pending flag.
- irq_addr_i  in  `inst_addr_bus`  handler address, captured with the request.
- hold_pc_o, hold_ifid_o, hold_idex_o, hold_exmem_o  out  `holdpip_bus` each  per-stage hold code.
- redirect_en_o  out  1  load PC from `redirect_addr_o`.
- redirect_addr_o  out  `inst_addr_bus`  new PC.
- irq_ack_o  out  1  one-cycle pulse on interrupt entry.
- bus_err_o  out  1  one-cycle pulse on bus timeout.
- stall_cnt_o  out  CNT_W  saturating count of cycles in which any output is `hold_wait`.

## Operation
- FSM states: IDLE, MDU_WAIT, IRQ_ENTER. Reset: IDLE, irq_pend=0, all counters 0.
- Hold codes: N=`hold_none`, W=`hold_wait`, F=`hold_flush`. Fields below are listed as (pc, ifid, idex, exmem).
- Priority in IDLE, first match wins:
  1. bus_wait_i: (W,W,W,W).
  2. jump_req_i: redirect_en=1, addr=jump_addr_i, (N,F,F,N).
  3. mdu_start_i & !mdu_done_i: (W,W,W,F), then go to MDU_WAIT.
  4. irq_pend: (W,W,F,N), then go to IRQ_ENTER.
  5. load_use_i: (W,W,F,N).
  6. Otherwise: (N,N,N,N).
- MDU_WAIT:
  - bus_wait_i gives (W,W,W,W).
  - Else !mdu_done_i gives (W,W,W,F).
  - Else mdu_done_i gives (N,N,N,N) and returns to IDLE.
  - jump_req_i and load_use_i are ignored.
- IRQ_ENTER:
  - bus_wait_i gives (W,W,W,W) and the FSM stays.
  - Otherwise: redirect_en=1, addr=latched irq_addr, (N,F,F,N), irq_ack_o=1, irq_pend cleared, return to IDLE.
- irq_pend is set when irq_req_i=1 and irq_pend=0; irq_addr_i is latched at that edge. Clearing has priority over setting in the ack cycle.
- A jump in the same cycle as an eligible irq wins. irq_pend stays set, and entry starts on the next eligible IDLE cycle.
- Bus timeout counter:
  - Increments each cycle bus_wait_i=1 and clears when bus_wait_i=0.
  - On reaching BUS_TIMEOUT, bus_err_o=1 for one cycle and the counter reloads 0.
  - Holds continue regardless.
- stall_cnt_o increments when any hold output equals W and saturates at all ones.

## Timing
- Hold outputs, redirect_en_o and redirect_addr_o are combinational from state, inputs and latched registers. Pipeline registers act on the same edge (zero latency).
- irq_ack_o is combinational in IRQ_ENTER.
- bus_err_o is registered: it is high on the cycle after the counter hits BUS_TIMEOUT.
- Interrupt entry latency, no blocking: irq_req_i at cycle 0, pending at cycle 1, IDLE drain at cycle 1, IRQ_ENTER redirect at cycle 2.
- Reset values: every hold output N, redirect_en_o 0, redirect_addr_o 0, irq_ack_o 0, bus_err_o 0, stall_cnt_o 0.
- Reset asserted mid-MDU_WAIT or mid-IRQ_ENTER: at the next edge the state returns to IDLE and irq_pend is dropped with no ack.

## Structure
- Hold codes `hold_none/hold_wait/hold_flush`, `holdpip_bus`, `inst_addr_bus` and FSM state encodings belong in the shared define file.
- Natural sub-module: `hold_timeout_cnt`, the BUS_TIMEOUT counter plus its registered error pulse.

## Test plan
- Reset then idle: all holds N, stall_cnt_o=0.
- jump_req_i=1, jump_addr_i=0x0000_0100: redirect_en=1, addr 0x100, (N,F,F,N) same cycle, stall_cnt_o unchanged.
- mdu_start_i at cycle 0, mdu_done_i at cycle 4:
  - Cycles 0–3: (W,W,W,F).
  - Cycle 4: all N.
  - stall_cnt_o=4.
- irq_req_i with irq_addr_i=0x80 at cycle 0, jump_req_i at cycle 1:
  - Cycle 1: jump wins.
  - Cycle 2: (W,W,F,N).
  - Cycle 3: redirect to 0x80, irq_ack_o=1.
- bus_wait_i held 300 cycles with BUS_TIMEOUT=255:
  - Holds (W,W,W,W) throughout.
  - bus_err_o pulses exactly once, on cycle 256.
- rst_n low for one edge during MDU_WAIT with irq_pend set: next cycle IDLE, all holds N, no irq_ack_o.
